// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: instruction memory handshake, redirect/stall controls
// and the IF/ID head of the prefetch queue.
interface fetch_prefetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_f;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
        input  imem_ack, imem_rdata, redirect, redirect_pc, stall_f
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
        output imem_ack, imem_rdata, redirect, redirect_pc, stall_f
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to a variable-latency
// memory, buffers responses, and flushes on branch/jump redirect.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                     clk,
    input logic                     reset,
    fetch_prefetch_queue_if.master  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e            state_q;
    logic [31:0]       fetch_pc_q;
    logic [PtrW:0]     count_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic              req_q;
    logic [31:0]       addr_q;
    logic [31:0]       pc_mem_q    [DEPTH];
    logic [31:0]       instr_mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic              can_issue;
    logic              head_valid;
    logic [PtrW:0]     count_next;
    logic [31:0]       target;
    logic [31:0]       pc_inc;
    logic [31:0]       head_pc;

    always_comb begin
        head_valid = (count_q != '0);
        target     = bus.redirect_pc & ~32'h3;
        pc_inc     = fetch_pc_q + 32'd4;
        // A response is only accepted for a live request; DISCARD acks are dropped.
        push       = (state_q == StReq) && bus.imem_ack && !bus.redirect;
        pop        = head_valid && !bus.stall_f && !bus.redirect;
        count_next = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
        can_issue  = (count_next < DepthCnt);
        head_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else if (bus.redirect) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fetch_pc_q <= target;
            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                    addr_q  <= target;
                end
                StReq: begin
                    // An unanswered request cannot be retracted; wait it out.
                    if (bus.imem_ack) addr_q <= target;
                    else              state_q <= StDiscard;
                end
                StDiscard: state_q <= StDiscard;
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end else begin
            count_q <= count_next;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (can_issue) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (bus.imem_ack) begin
                        fetch_pc_q <= pc_inc;
                        if (can_issue) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end
                    end
                end
                StDiscard: begin
                    if (bus.imem_ack) begin
                        state_q <= StReq;
                        addr_q  <= fetch_pc_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            pc_mem_q[wr_ptr_q]    <= addr_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = head_pc;
    assign bus.pc_plus4    = head_pc + 32'd4;
endmodule
